// File: rtl/exc_ctrl_pkg.sv
// Shared constants for the exception sequencer: cause codes, Status bit
// positions, request-kind and FSM state encodings, exception vector.
package exc_ctrl_pkg;

    typedef enum logic [1:0] {
        KIND_SYSCALL = 2'd0,
        KIND_BREAK   = 2'd1,
        KIND_TEQ     = 2'd2,
        KIND_ERET    = 2'd3
    } req_kind_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    localparam logic [4:0] EXC_IRQ     = 5'd0;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_BREAK   = 5'd9;
    localparam logic [4:0] EXC_TEQ     = 5'd13;

    localparam int STAT_IE  = 0;
    localparam int STAT_SYS = 1;
    localparam int STAT_BRK = 2;
    localparam int STAT_TEQ = 3;
    localparam int STAT_INT = 4;

    localparam logic [31:0] EXC_VECTOR = 32'h0040_0004;

endpackage

// File: rtl/exc_prio.sv
// Masks decode requests and the interrupt against Status and picks the winner;
// a present decode request (taken or masked) always beats the interrupt.
module exc_prio
    import exc_ctrl_pkg::*;
(
    input  logic [31:0] status,
    input  logic        req_valid,
    input  logic [1:0]  req_kind,
    input  logic        teq_equal,
    input  logic        irq,
    input  logic        id_valid,
    output logic        take,
    output logic        is_eret,
    output logic        from_req,
    output logic        req_masked,
    output logic [4:0]  cause
);

    logic req_take_s;
    logic [4:0] req_cause_s;
    logic irq_en_s;

    assign irq_en_s = irq & status[STAT_IE] & status[STAT_INT] & id_valid;

    // Per-kind enable and cause code for the decode request
    always_comb begin
        req_take_s  = 1'b0;
        req_cause_s = EXC_IRQ;
        case (req_kind)
            KIND_SYSCALL: begin
                req_take_s  = status[STAT_IE] & status[STAT_SYS];
                req_cause_s = EXC_SYSCALL;
            end
            KIND_BREAK: begin
                req_take_s  = status[STAT_IE] & status[STAT_BRK];
                req_cause_s = EXC_BREAK;
            end
            KIND_TEQ: begin
                req_take_s  = status[STAT_IE] & status[STAT_TEQ] & teq_equal;
                req_cause_s = EXC_TEQ;
            end
            KIND_ERET: begin
                req_take_s  = 1'b1;
                req_cause_s = EXC_IRQ;
            end
            default: begin
                req_take_s  = 1'b0;
                req_cause_s = EXC_IRQ;
            end
        endcase
    end

    // Arbitrate between the decode request and the interrupt
    always_comb begin
        take       = 1'b0;
        is_eret    = 1'b0;
        from_req   = 1'b0;
        req_masked = 1'b0;
        cause      = EXC_IRQ;
        if (req_valid) begin
            take       = req_take_s;
            is_eret    = (req_kind == KIND_ERET);
            from_req   = 1'b1;
            req_masked = ~req_take_s;
            cause      = req_cause_s;
        end else begin
            take       = irq_en_s;
            is_eret    = 1'b0;
            from_req   = 1'b0;
            req_masked = 1'b0;
            cause      = EXC_IRQ;
        end
    end

endmodule

// File: rtl/exc_ctrl.sv
// Exception sequencer: captures a taken event, stalls decode until the pipe
// drains, then issues a one-cycle exception/eret commit and PC redirect.
module exc_ctrl
    import exc_ctrl_pkg::*;
(
    input  logic        in_clk,
    input  logic        in_rst,
    input  logic        in_id_valid,
    input  logic [31:0] in_id_pc,
    input  logic        in_req_valid,
    input  logic [1:0]  in_req_kind,
    input  logic        in_teq_equal,
    input  logic        in_irq,
    input  logic        in_pipe_empty,
    input  logic [31:0] in_status,
    input  logic [31:0] in_eaddr,
    output logic        out_stall,
    output logic        out_req_ack,
    output logic        out_exception,
    output logic        out_eret,
    output logic [4:0]  out_cause,
    output logic [31:0] out_epc,
    output logic        out_redirect,
    output logic [31:0] out_target
);

    state_e      state_r;
    state_e      state_s;
    logic        take_s;
    logic        is_eret_s;
    logic        from_req_s;
    logic        masked_s;
    logic [4:0]  cause_s;
    logic        eret_r;
    logic        from_req_r;
    logic        mask_ack_r;
    logic [4:0]  cause_r;
    logic [31:0] epc_r;
    logic        idle_s;

    exc_prio u_prio (
        .status     (in_status),
        .req_valid  (in_req_valid),
        .req_kind   (in_req_kind),
        .teq_equal  (in_teq_equal),
        .irq        (in_irq),
        .id_valid   (in_id_valid),
        .take       (take_s),
        .is_eret    (is_eret_s),
        .from_req   (from_req_s),
        .req_masked (masked_s),
        .cause      (cause_s)
    );

    assign idle_s = (state_r == ST_IDLE);

    // FSM state register
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; events are only sampled in IDLE
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE:   state_s = take_s ? ST_DRAIN : ST_IDLE;
            ST_DRAIN:  state_s = in_pipe_empty ? ST_COMMIT : ST_DRAIN;
            ST_COMMIT: state_s = ST_IDLE;
            default:   state_s = ST_IDLE;
        endcase
    end

    // Event capture and masked-request acknowledge
    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            eret_r     <= 1'b0;
            from_req_r <= 1'b0;
            mask_ack_r <= 1'b0;
            cause_r    <= 5'd0;
            epc_r      <= 32'd0;
        end else begin
            mask_ack_r <= idle_s & masked_s;
            if (idle_s && take_s) begin
                eret_r     <= is_eret_s;
                from_req_r <= from_req_s;
                cause_r    <= cause_s;
                epc_r      <= in_id_pc;
            end
        end
    end

    // Output decode; stall is raised combinationally on a take in IDLE
    always_comb begin
        out_stall     = 1'b0;
        out_exception = 1'b0;
        out_eret      = 1'b0;
        out_redirect  = 1'b0;
        out_req_ack   = mask_ack_r;
        case (state_r)
            ST_IDLE: begin
                out_stall = take_s & in_rst;
            end
            ST_DRAIN: begin
                out_stall = 1'b1;
            end
            ST_COMMIT: begin
                out_stall     = 1'b1;
                out_exception = ~eret_r;
                out_eret      = eret_r;
                out_redirect  = 1'b1;
                out_req_ack   = mask_ack_r | from_req_r;
            end
            default: begin
                out_stall = 1'b0;
            end
        endcase
    end

    assign out_cause  = cause_r;
    assign out_epc    = epc_r;
    assign out_target = in_eaddr;

endmodule
